// File: rtl/rv32i_alu.sv
// rv32i_alu -- RV32I execute-stage integer ALU with registered result and flags.
//
// The operation code is {funct7[5], funct3}, so the decoder can pass instruction
// bits straight through. The result and flags are captured on the rising clock
// edge, giving one cycle of latency. A new operation is accepted every cycle.
//
// Ports:
//   clk            system clock, rising-edge active
//   rst            asynchronous active-high reset; clears all outputs
//   op   [3:0]     operation select
//   a    [XLEN-1:0] operand A (rs1 or PC)
//   b    [XLEN-1:0] operand B (rs2 or immediate); shift amount is b[4:0]
//   result [XLEN-1:0] registered operation result
//   zero_flag      registered, 1 when result == 0 (forced to 0 in reset)
//   negative_flag  registered, result[XLEN-1]
//   overflow_flag  registered, signed overflow of ADD/SUB, else 0
module rv32i_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    output logic            negative_flag,
    output logic            overflow_flag
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1101;

    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] diff_s;
    logic [4:0]      shamt_s;
    logic            lt_signed_s;
    logic            lt_unsigned_s;
    logic            ovf_add_s;
    logic            ovf_sub_s;
    logic [XLEN-1:0] result_s;
    logic            overflow_s;

    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            negative_r;
    logic            overflow_r;

    // Shared arithmetic, comparisons and overflow detection.
    always_comb begin
        sum_s   = a + b;
        diff_s  = a - b;
        shamt_s = b[4:0];
        // Signed compare is done directly rather than from the wrapped
        // difference, so 0x7FFFFFFF vs 0x80000000 resolves correctly.
        lt_signed_s   = ($signed(a) < $signed(b));
        lt_unsigned_s = (a < b);
        ovf_add_s = (a[XLEN-1] == b[XLEN-1]) && (sum_s[XLEN-1]  != a[XLEN-1]);
        ovf_sub_s = (a[XLEN-1] != b[XLEN-1]) && (diff_s[XLEN-1] != a[XLEN-1]);
    end

    // Operation select; unused codes produce zero with no overflow.
    always_comb begin
        result_s   = '0;
        overflow_s = 1'b0;
        case (op)
            OP_ADD: begin
                result_s   = sum_s;
                overflow_s = ovf_add_s;
            end
            OP_SUB: begin
                result_s   = diff_s;
                overflow_s = ovf_sub_s;
            end
            OP_SLL:   result_s = a << shamt_s;
            OP_SLT:   result_s = {{(XLEN-1){1'b0}}, lt_signed_s};
            OP_SLTU:  result_s = {{(XLEN-1){1'b0}}, lt_unsigned_s};
            OP_XOR:   result_s = a ^ b;
            OP_SRL:   result_s = a >> shamt_s;
            OP_SRA:   result_s = $unsigned($signed(a) >>> shamt_s);
            OP_OR:    result_s = a | b;
            OP_AND:   result_s = a & b;
            OP_PASSB: result_s = b;
            default: begin
                result_s   = '0;
                overflow_s = 1'b0;
            end
        endcase
    end

    // Output register; the zero flag is cleared in reset rather than derived.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r   <= '0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            result_r   <= result_s;
            zero_r     <= (result_s == '0);
            negative_r <= result_s[XLEN-1];
            overflow_r <= overflow_s;
        end
    end

    assign result        = result_r;
    assign zero_flag     = zero_r;
    assign negative_flag = negative_r;
    assign overflow_flag = overflow_r;

endmodule

// File: tb/tb_rv32i_alu.sv
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero_flag;
    logic        negative_flag;
    logic        overflow_flag;

    int n_pass  = 0;
    int n_total = 0;

    rv32i_alu #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .op(op),
        .a(a),
        .b(b),
        .result(result),
        .zero_flag(zero_flag),
        .negative_flag(negative_flag),
        .overflow_flag(overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        o;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] er,
                         input logic ez, input logic en, input logic eo);
        n_total++;
        if ({result, zero_flag, negative_flag, overflow_flag} === {er, ez, en, eo})
            n_pass++;
        else
            $display("FAIL %s: got result=%h z=%b n=%b o=%b, expected result=%h z=%b n=%b o=%b",
                     name, result, zero_flag, negative_flag, overflow_flag, er, ez, en, eo);
    endtask

    // Reference model computed from arithmetic definitions of each operation.
    function automatic void model(input logic [3:0] mop, input logic [31:0] ma,
                                  input logic [31:0] mb, output logic [31:0] r,
                                  output logic o);
        longint          sa;
        longint          sb;
        longint          exact;
        longint          q;
        longint          ps;
        longint unsigned ua;
        longint unsigned p;
        longint unsigned prod;
        int              sh;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = 64'(ma);
        sh = int'(mb % 32'd32);
        p  = 64'd1 << sh;
        ps = longint'(p);
        r = 32'd0;
        o = 1'b0;
        case (mop)
            4'd0: begin
                exact = sa + sb;
                r = ma + mb;
                o = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            4'd8: begin
                exact = sa - sb;
                r = ma - mb;
                o = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
            end
            4'd1: begin
                prod = ua * p;
                r = prod[31:0];
            end
            4'd5: r = ma / p[31:0];
            4'd13: begin
                q = sa / ps;
                if (sa < 0 && (sa % ps) != 0) q = q - 1;
                r = q[31:0];
            end
            4'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: r = (ua < 64'(mb)) ? 32'd1 : 32'd0;
            4'd4: r = ma ^ mb;
            4'd6: r = ma | mb;
            4'd7: r = ma & mb;
            4'd9: r = mb;
            default: r = 32'd0;
        endcase
    endfunction

    task automatic apply(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
        @(negedge clk);
        op = t_op;
        a  = t_a;
        b  = t_b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        else
            return $urandom;
    endfunction

    initial begin
        logic [31:0] er;
        logic        eo;

        vecs.push_back('{"add_ovf",    4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"add_neg_ovf",4'b0000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"sub_ovf",    4'b1000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_ovf2",   4'b1000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{"sub_zero",   4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"slt_neg1",   4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sltu_big",   4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sltu_small", 4'b0011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"slt_min",    4'b0010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"slt_max",    4'b0010, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sll_31",     4'b0001, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"srl_4",      4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sra_4",      4'b1101, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sll_0",      4'b0001, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"srl_0",      4'b0101, 32'h87654321, 32'h00000020, 32'h87654321, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"sra_0",      4'b1101, 32'h80000001, 32'h00000000, 32'h80000001, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"xor",        4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"or",         4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"and",        4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"passb",      4'b1001, 32'hDEADBEEF, 32'h12345000, 32'h12345000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"op_1111",    4'b1111, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"op_1010",    4'b1010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"op_1100",    4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0});

        // Reset state before any clock edge.
        rst = 1'b1;
        op  = 4'b0000;
        a   = 32'd0;
        b   = 32'd0;
        #1;
        check("reset_init", 32'd0, 1'b0, 1'b0, 1'b0);

        // Release reset with an operation already presented.
        @(negedge clk);
        rst = 1'b0;
        op  = 4'b0000;
        a   = 32'd5;
        b   = 32'd7;
        @(posedge clk);
        #1;
        check("add_after_reset", 32'd12, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        apply(4'b0000, 32'h7FFFFFFF, 32'h00000001);
        check("pre_async_rst", 32'h80000000, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_held", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        op  = 4'b0000;
        a   = 32'd5;
        b   = 32'd7;
        @(posedge clk);
        #1;
        check("add_5_7", 32'd12, 1'b0, 1'b0, 1'b0);

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].name, vecs[i].r, vecs[i].z, vecs[i].n, vecs[i].o);
        end

        // Back-to-back ops: outputs hold until the edge, then update with no bubble.
        apply(4'b0000, 32'd3, 32'd4);
        check("b2b_add", 32'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        op = 4'b1000; a = 32'd3; b = 32'd4;
        #1;
        check("b2b_hold", 32'd7, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("b2b_sub", 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        apply(4'b0111, 32'hFFFF0000, 32'h0F0F0F0F);
        check("b2b_and", 32'h0F0F0000, 1'b0, 1'b0, 1'b0);
        apply(4'b1101, 32'hF0000000, 32'h00000008);
        check("b2b_sra", 32'hFFF00000, 1'b0, 1'b1, 1'b0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 4'($urandom_range(0, 15));
            ra  = pick_operand();
            rb  = pick_operand();
            model(rop, ra, rb, er, eo);
            apply(rop, ra, rb);
            check($sformatf("rand_op%0d_%h_%h", rop, ra, rb), er, (er == 32'd0), er[31], eo);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32i_alu.md
Name: rv32i_alu

Overview:
- Integer ALU for the RV32I execute stage.
- Takes a 4-bit operation code and two 32-bit operands; returns a 32-bit result plus zero, negative and signed-overflow flags.
- Result and flags are registered, one clock of latency, so the block can sit directly on an execute/memory pipeline boundary.
- The op code is {funct7[5], funct3} of the instruction, so the decoder passes instruction bits through with minimal logic.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; a shift amount is always b[4:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  4  operation select (encoding below)
- a  input  32  operand A (rs1 or PC)
- b  input  32  operand B (rs2 or immediate)
- result  output  32  registered operation result
- zero_flag  output  1  registered; 1 when result == 0
- negative_flag  output  1  registered; equals result[31]
- overflow_flag  output  1  registered; signed overflow of ADD/SUB

Behaviour:
- Reset: while rst is high, asynchronously force result = 0, zero_flag = 0, negative_flag = 0, overflow_flag = 0.
  - The zero flag is deliberately 0 in reset, not derived from result.
- Reset deasserting mid-operation: the first rising edge after release captures the current op/a/b normally.
- Latency: the combinational value for the op/a/b present at a rising edge appears on the outputs after that edge and holds until the next edge.
  - No enable and no handshake; a new operation is accepted every cycle.
- Op encoding (all arithmetic modulo 2^32):
  - 0000 ADD: a + b
  - 1000 SUB: a - b
  - 0001 SLL: a << b[4:0]
  - 0010 SLT: 1 if signed(a) < signed(b), else 0
  - 0011 SLTU: 1 if unsigned(a) < unsigned(b), else 0
  - 0100 XOR: a ^ b
  - 0101 SRL: logical a >> b[4:0], zero fill
  - 1101 SRA: arithmetic a >> b[4:0], sign fill from a[31]
  - 0110 OR: a | b
  - 0111 AND: a & b
  - 1001 PASSB: result = b (used for LUI)
  - All other codes (1010, 1011, 1100, 1110, 1111): result = 0, overflow = 0.
- Shifts: b[31:5] is ignored. A shift amount of 0 returns a unchanged.
- SLT/SLTU: result[31:1] is always 0. The comparison must not be derived from the wrapped subtraction without overflow correction.
- Flags, computed from the combinational result and registered with it:
  - zero_flag = (result == 0)
  - negative_flag = result[31]
  - overflow_flag for ADD = a[31] == b[31] and sum[31] != a[31]
  - overflow_flag for SUB = a[31] != b[31] and diff[31] != a[31]
  - overflow_flag = 0 for every other op
- No carry flag and no exceptions; wrap-around is silent.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all four outputs go to 0 immediately, before any clock edge. Release rst, apply ADD 5 + 7 -> result = 12 after the next edge, zero_flag = 0.
- Overflow:
  - ADD 0x7FFFFFFF + 1 -> result 0x80000000, overflow = 1, negative = 1.
  - SUB 0x80000000 - 1 -> 0x7FFFFFFF, overflow = 1.
  - SUB 5 - 5 -> result 0, zero_flag = 1, overflow = 0.
- Compares:
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU 0xFFFFFFFF vs 1 -> 0.
  - SLT 0x80000000 vs 0x7FFFFFFF -> 1.
- Shifts:
  - SLL 1 by b = 0x0000003F (amount 31) -> 0x80000000.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - Any shift by 0 -> a.
- Logic and pass:
  - a = 0xF0F0F0F0, b = 0x0FF00FF0: XOR -> 0xFF00FF00, OR -> 0xFFF0FFF0, AND -> 0x00F000F0.
  - PASSB with b = 0x12345000 -> 0x12345000.
  - Op 1111 -> 0 with zero_flag = 1.
- Back-to-back: change op every cycle (ADD, SUB, AND, SRA) -> each result appears exactly one edge after its inputs, with no bubbles.
